// File: rtl/fir_sched_pkg.sv
// Shared types, default sizes and ring-pointer helpers for the FIR channel scheduler.
package fir_sched_pkg;

  localparam int NCH_DEF     = 3;
  localparam int NTAPS_DEF   = 33;
  localparam int DW_DEF      = 24;
  localparam int MAC_LAT_DEF = 2;

  localparam int CH_W  = $clog2(NCH_DEF);
  localparam int PTR_W = $clog2(NTAPS_DEF);

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_WRITE = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic [PTR_W-1:0] ring_inc(input logic [PTR_W-1:0] p, input int depth);
    if (int'(p) == depth - 1) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + 1'b1;
    end
  endfunction

  // Tap k of a write at p lives k entries behind it on the ring.
  function automatic logic [PTR_W-1:0] ring_sub(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W-1:0] k,
                                                input int depth);
    if (p >= k) begin
      return p - k;
    end else begin
      return PTR_W'(int'(p) + depth - int'(k));
    end
  endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin grant over the pending vector; search starts one past the last winner.
module fir_rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  pending,
  input  logic            advance,
  output logic            grant_valid,
  output logic [CH_W-1:0] grant_idx
);

  logic [CH_W-1:0] start_r;
  logic [CH_W-1:0] idx_s;

  // First pending channel found walking up from start_r with wrap.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = {CH_W{1'b0}};
    idx_s       = {CH_W{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      idx_s = CH_W'((int'(start_r) + i) % NCH);
      if (!grant_valid && pending[idx_s]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_s;
      end else begin
        grant_idx = grant_idx;
      end
    end
  end

  // Move the search origin past the channel just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_r <= {CH_W{1'b0}};
    end else if (advance) begin
      start_r <= (int'(grant_idx) == NCH - 1) ? {CH_W{1'b0}} : grant_idx + 1'b1;
    end else begin
      start_r <= start_r;
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Control sequencer sharing one MAC datapath across NCH FIR channels:
// capture, arbitrate, write delay line, step taps, flag results.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int NTAPS   = NTAPS_DEF,
  parameter int DW      = DW_DEF,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              dl_wr_en,
  output logic [CH_W-1:0]   dl_wr_ch,
  output logic [PTR_W-1:0]  dl_wr_ptr,
  output logic [DW-1:0]     dl_wr_data,
  output logic [PTR_W-1:0]  dl_rd_ptr,
  output logic [PTR_W-1:0]  coef_addr,
  output logic [CH_W-1:0]   ch_sel,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              mac_last,
  output logic              out_valid,
  output logic [CH_W-1:0]   out_ch,
  output logic [NCH-1:0]    overrun,
  output logic              busy
);

  localparam int DRW = $clog2(MAC_LAT + 1);

  state_t           state_r, state_nx;
  logic             started_r;
  logic [CH_W-1:0]  flush_ch_r, ch_r;
  logic [PTR_W-1:0] flush_ptr_r, tap_r, wptr_r;
  logic [DRW-1:0]   drain_r;
  logic [PTR_W-1:0] head_r [NCH];
  logic [DW-1:0]    pdata_r [NCH];
  logic [NCH-1:0]   pend_r, overrun_r;
  logic             grant_valid, arb_adv;
  logic [CH_W-1:0]  grant_idx;
  logic             flush_last_s, tap_last_s, drain_last_s;

  assign flush_last_s = (int'(flush_ch_r) == NCH - 1) && (int'(flush_ptr_r) == NTAPS - 1);
  assign tap_last_s   = (int'(tap_r) == NTAPS - 1);
  assign drain_last_s = (int'(drain_r) == MAC_LAT - 1);
  assign in_ready     = (state_r == ST_FLUSH) ? {NCH{1'b0}} : ~pend_r;
  assign overrun      = overrun_r;
  assign busy         = (state_r != ST_IDLE);

  fir_rr_arbiter #(.NCH(NCH)) u_arb (
    .clk        (clk),
    .rst_n      (reset),
    .pending    (pend_r),
    .advance    (arb_adv),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_FLUSH;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state and datapath controls, decoded from registered state only.
  always_comb begin
    state_nx   = state_r;
    dl_wr_en   = 1'b0;
    dl_wr_ch   = {CH_W{1'b0}};
    dl_wr_ptr  = {PTR_W{1'b0}};
    dl_wr_data = {DW{1'b0}};
    dl_rd_ptr  = {PTR_W{1'b0}};
    coef_addr  = {PTR_W{1'b0}};
    ch_sel     = {CH_W{1'b0}};
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    mac_last   = 1'b0;
    out_valid  = 1'b0;
    out_ch     = {CH_W{1'b0}};
    arb_adv    = 1'b0;
    case (state_r)
      ST_FLUSH: begin
        // started_r keeps the write strobe low while reset is held.
        if (started_r) begin
          dl_wr_en  = 1'b1;
          dl_wr_ch  = flush_ch_r;
          dl_wr_ptr = flush_ptr_r;
          state_nx  = flush_last_s ? ST_IDLE : ST_FLUSH;
        end else begin
          state_nx = ST_FLUSH;
        end
      end
      ST_IDLE: begin
        if (grant_valid) begin
          arb_adv  = 1'b1;
          state_nx = ST_WRITE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WRITE: begin
        ch_sel     = ch_r;
        dl_wr_en   = 1'b1;
        dl_wr_ch   = ch_r;
        dl_wr_ptr  = head_r[ch_r];
        dl_wr_data = pdata_r[ch_r];
        state_nx   = ST_RUN;
      end
      ST_RUN: begin
        ch_sel    = ch_r;
        mac_en    = 1'b1;
        coef_addr = tap_r;
        dl_rd_ptr = ring_sub(wptr_r, tap_r, NTAPS);
        mac_clr   = (tap_r == {PTR_W{1'b0}});
        mac_last  = tap_last_s;
        state_nx  = tap_last_s ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        ch_sel   = ch_r;
        state_nx = drain_last_s ? ST_DONE : ST_DRAIN;
      end
      ST_DONE: begin
        ch_sel    = ch_r;
        out_valid = 1'b1;
        out_ch    = ch_r;
        state_nx  = ST_IDLE;
      end
      default: begin
        state_nx = ST_FLUSH;
      end
    endcase
  end

  // Flush walker, granted channel, write pointer, tap and drain counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_r   <= 1'b0;
      flush_ch_r  <= {CH_W{1'b0}};
      flush_ptr_r <= {PTR_W{1'b0}};
      ch_r        <= {CH_W{1'b0}};
      wptr_r      <= {PTR_W{1'b0}};
      tap_r       <= {PTR_W{1'b0}};
      drain_r     <= {DRW{1'b0}};
    end else begin
      started_r <= 1'b1;
      case (state_r)
        ST_FLUSH: begin
          if (started_r && int'(flush_ptr_r) == NTAPS - 1) begin
            flush_ptr_r <= {PTR_W{1'b0}};
            flush_ch_r  <= flush_ch_r + 1'b1;
          end else if (started_r) begin
            flush_ptr_r <= flush_ptr_r + 1'b1;
          end else begin
            flush_ptr_r <= flush_ptr_r;
          end
        end
        ST_IDLE: begin
          ch_r <= grant_valid ? grant_idx : ch_r;
        end
        ST_WRITE: begin
          wptr_r <= head_r[ch_r];
          tap_r  <= {PTR_W{1'b0}};
        end
        ST_RUN: begin
          tap_r   <= tap_r + 1'b1;
          drain_r <= {DRW{1'b0}};
        end
        ST_DRAIN: begin
          drain_r <= drain_r + 1'b1;
        end
        default: begin
          tap_r <= tap_r;
        end
      endcase
    end
  end

  // Per-channel sample capture, head pointers and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r    <= {NCH{1'b0}};
      overrun_r <= {NCH{1'b0}};
      for (int c = 0; c < NCH; c++) begin
        head_r[c]  <= {PTR_W{1'b0}};
        pdata_r[c] <= {DW{1'b0}};
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (state_r == ST_WRITE && ch_r == CH_W'(c)) begin
          pend_r[c] <= 1'b0;
          head_r[c] <= ring_inc(head_r[c], NTAPS);
        end else if (in_valid[c] && in_ready[c]) begin
          pend_r[c]  <= 1'b1;
          pdata_r[c] <= in_data[c*DW +: DW];
        end else begin
          pend_r[c] <= pend_r[c];
        end
        if (in_valid[c] && pend_r[c]) begin
          overrun_r[c] <= 1'b1;
        end else begin
          overrun_r[c] <= overrun_r[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: vector table plus flush, wrap, overrun and abort sequences.
module tb_fir_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  in_valid = 3'b000;
  logic [71:0] in_data = 72'd0;
  logic [2:0]  in_ready;
  logic        dl_wr_en;
  logic [1:0]  dl_wr_ch;
  logic [5:0]  dl_wr_ptr;
  logic [23:0] dl_wr_data;
  logic [5:0]  dl_rd_ptr;
  logic [5:0]  coef_addr;
  logic [1:0]  ch_sel;
  logic        mac_clr, mac_en, mac_last, out_valid, busy;
  logic [1:0]  out_ch;
  logic [2:0]  overrun;

  int n_vec = 0;
  int n_bad = 0;

  fir_channel_scheduler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dl_wr_en(dl_wr_en), .dl_wr_ch(dl_wr_ch), .dl_wr_ptr(dl_wr_ptr), .dl_wr_data(dl_wr_data),
    .dl_rd_ptr(dl_rd_ptr), .coef_addr(coef_addr), .ch_sel(ch_sel), .mac_clr(mac_clr),
    .mac_en(mac_en), .mac_last(mac_last), .out_valid(out_valid), .out_ch(out_ch),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  strobe;
    logic [71:0] data;
    logic [1:0]  n;
    logic [5:0]  ord;
    logic [17:0] ptr;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic [2:0] m, input logic [71:0] d);
    in_valid = m;
    in_data  = d;
    @(negedge clk);
    in_valid = 3'b000;
  endtask

  task automatic flush_check();
    bit found = 0;
    for (int w = 0; w < 5; w++) begin
      if (dl_wr_en) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("flush_start", 128'(found), 128'd1);
    for (int i = 0; i < 99; i++) begin
      chk("flush", {dl_wr_en, dl_wr_ch, dl_wr_ptr, dl_wr_data, in_ready, busy},
          {1'b1, 2'(i / 33), 6'(i % 33), 24'd0, 3'b000, 1'b1});
      @(negedge clk);
    end
    chk("flush_end", {dl_wr_en, in_ready, busy, overrun}, {1'b0, 3'b111, 1'b0, 3'b000});
  endtask

  // Follows one grant from WRITE through DONE, checking every cycle.
  task automatic serve_one(input int ch, input logic [23:0] d, input int p);
    bit found = 0;
    for (int w = 0; w < 60; w++) begin
      if (dl_wr_en) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("write_seen", 128'(found), 128'd1);
    if (!found) return;
    chk("write", {dl_wr_ch, dl_wr_ptr, dl_wr_data, ch_sel, mac_en, busy},
        {2'(ch), 6'(p), d, 2'(ch), 1'b0, 1'b1});
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      chk("tap", {mac_en, mac_clr, mac_last, coef_addr, dl_rd_ptr, ch_sel, dl_wr_en, out_valid},
          {1'b1, (k == 0), (k == 32), 6'(k), 6'((p - k + 33) % 33), 2'(ch), 1'b0, 1'b0});
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk("drain", {mac_en, out_valid, ch_sel}, {1'b0, 1'b0, 2'(ch)});
    end
    @(negedge clk);
    chk("done", {out_valid, out_ch, ch_sel}, {1'b1, 2'(ch), 2'(ch)});
  endtask

  initial begin
    int ch;
    int ov_cnt;
    vecs[0] = '{3'b111, {24'h300003, 24'h200002, 24'h000001}, 2'd3,
                {2'd2, 2'd1, 2'd0}, {6'd0, 6'd0, 6'd0}};
    vecs[1] = '{3'b001, {24'h0, 24'h0, 24'h7FFFFF}, 2'd1, {2'd0, 2'd0, 2'd0}, {6'd0, 6'd0, 6'd1}};
    vecs[2] = '{3'b100, {24'h800000, 24'h0, 24'h0}, 2'd1, {2'd0, 2'd0, 2'd2}, {6'd0, 6'd0, 6'd1}};
    vecs[3] = '{3'b110, {24'h123456, 24'hABCDEF, 24'h0}, 2'd2,
                {2'd0, 2'd2, 2'd1}, {6'd0, 6'd2, 6'd1}};
    vecs[4] = '{3'b101, {24'hFFFFFF, 24'h0, 24'h000055}, 2'd2,
                {2'd0, 2'd2, 2'd0}, {6'd0, 6'd3, 6'd2}};

    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", {in_ready, dl_wr_en, dl_wr_ch, dl_wr_ptr, dl_wr_data, dl_rd_ptr, coef_addr,
        ch_sel, mac_clr, mac_en, mac_last, out_valid, out_ch, overrun}, 128'd0);
    chk("reset_busy", 128'(busy), 128'd1);
    @(negedge clk);
    reset = 1'b1;
    flush_check();

    for (int v = 0; v < 5; v++) begin
      strobe(vecs[v].strobe, vecs[v].data);
      for (int j = 0; j < int'(vecs[v].n); j++) begin
        ch = int'(vecs[v].ord[2*j +: 2]);
        serve_one(ch, vecs[v].data[24*ch +: 24], int'(vecs[v].ptr[6*j +: 6]));
      end
    end
    @(negedge clk);
    chk("idle_after_table", {busy, in_ready, overrun}, {1'b0, 3'b111, 3'b000});

    // ch1 head starts at 2; the 32nd sample wraps 32 -> 0.
    for (int i = 0; i < 34; i++) begin
      strobe(3'b010, {24'h0, 24'(i + 16), 24'h0});
      serve_one(1, 24'(i + 16), (2 + i) % 33);
    end
    strobe(3'b001, {48'h0, 24'h000AAA});
    serve_one(0, 24'h000AAA, 3);
    strobe(3'b100, {24'h000BBB, 48'h0});
    serve_one(2, 24'h000BBB, 4);

    // ch0 accepted once, then strobed twice more while still pending.
    in_valid = 3'b001;
    in_data  = {48'h0, 24'h00000A};
    @(negedge clk);
    in_data = {48'h0, 24'h00000B};
    fork
      serve_one(0, 24'h00000A, 4);
      begin
        @(negedge clk);
        in_data = {48'h0, 24'h00000C};
        @(negedge clk);
        in_valid = 3'b000;
      end
    join
    chk("overrun_set", 128'(overrun), 128'd1);
    ov_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("no_extra_result", 128'(ov_cnt), 128'd0);
    chk("overrun_sticky", {overrun, busy}, {3'b001, 1'b0});
    strobe(3'b010, {24'h0, 24'h000CCC, 24'h0});
    serve_one(1, 24'h000CCC, 3);
    chk("overrun_hold", 128'(overrun), 128'd1);

    // Abort at RUN k=10.
    strobe(3'b100, {24'h00BEEF, 48'h0});
    for (int w = 0; w < 10 && !dl_wr_en; w++) @(negedge clk);
    chk("abort_write", {dl_wr_en, dl_wr_ch, dl_wr_ptr}, {1'b1, 2'd2, 6'd5});
    repeat (11) @(negedge clk);
    chk("abort_k10", {mac_en, coef_addr, dl_rd_ptr}, {1'b1, 6'd10, 6'd28});
    #1 reset = 1'b0;
    #1;
    chk("abort_outs", {in_ready, dl_wr_en, dl_wr_ch, dl_wr_ptr, dl_wr_data, dl_rd_ptr, coef_addr,
        ch_sel, mac_clr, mac_en, mac_last, out_valid, out_ch, overrun}, 128'd0);
    chk("abort_busy", 128'(busy), 128'd1);
    ov_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid || dl_wr_en) ov_cnt++;
    end
    chk("abort_quiet", 128'(ov_cnt), 128'd0);
    reset = 1'b1;
    flush_check();
    strobe(3'b001, {48'h0, 24'h000001});
    serve_one(0, 24'h000001, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
